// File: rtl/frame_capture.sv
// -----------------------------------------------------------------------------
// frame_capture
//
// Buffers whole N-sample frames from the windowed sample stream into a
// two-bank ping-pong RAM and replays each complete frame downstream over a
// valid/ready handshake, in natural or bit-reversed address order.
// Frames that arrive while no bank is free are dropped (overflow), and frames
// cut short by di_valid falling are discarded (partial). Both flags are sticky.
//
// Ports
//   clk         single clock
//   arst_n      asynchronous active-low reset
//   clk_en      input-side qualifier; a sample is taken only when high
//   di_valid    high for each in-frame input sample
//   di          signed input sample
//   dout_valid  output sample valid
//   dout_ready  downstream accepts when dout_valid & dout_ready
//   dout        signed output sample
//   dout_last   high with the sample of natural index N-1
//   dout_idx    natural-order index of the sample on dout
//   overflow    sticky: a frame was dropped because no bank was free
//   partial     sticky: di_valid fell before a frame was complete
//   status_clr  clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module frame_capture #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 14,
    parameter bit BIT_REV    = 1'b0
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         clk_en,
    input  logic                         di_valid,
    input  logic signed [DATA_WIDTH-1:0] di,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_last,
    output logic [$clog2(N)-1:0]         dout_idx,
    output logic                         overflow,
    output logic                         partial,
    input  logic                         status_clr
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_STREAM = 1'b1;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Storage and state
    // ---------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] mem [0:2*N-1];
    logic signed [DATA_WIDTH-1:0] ram_rd;

    logic [1:0]    wstate_q, wstate_d;
    logic          wbank_q, wbank_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          partial_q, partial_d;

    logic [0:0]    rstate_q, rstate_d;
    logic          ibank_q, ibank_d;
    logic [AW-1:0] iaddr_q, iaddr_d;
    logic          obank_q, obank_d;

    // Output stage: entry A is the RAM read register, entry S is the skid
    // entry holding the older sample whenever both are occupied.
    logic          vld_a_q, vld_a_d;
    logic [AW-1:0] a_idx_q, a_idx_d;
    logic          a_last_q, a_last_d;
    logic          vld_s_q, vld_s_d;
    logic [AW-1:0] s_idx_q, s_idx_d;
    logic          s_last_q, s_last_d;
    logic signed [DATA_WIDTH-1:0] s_data_q, s_data_d;

    logic          accept, gap;
    logic          we;
    logic [AW:0]   waddr;
    logic          set_full, ovf_set, par_set;
    logic          target_empty;
    logic          pop, rel, issue, issue_ok, move_a;
    logic [AW-1:0] raddr;
    logic          cur_last;

    assign accept = clk_en & di_valid;
    assign gap    = clk_en & ~di_valid;
    // wcnt_q is zero in W_IDLE, so the first sample of a frame lands at 0.
    assign waddr  = {wbank_q, wcnt_q};

    // A bank released by the reader in this very cycle is already free;
    // without this forwarding back-to-back frames would overflow.
    assign target_empty = ~full_q[wbank_q] | (rel & (obank_q == wbank_q));

    // ---------------------------------------------------------------------
    // Writer
    // ---------------------------------------------------------------------
    always_comb begin
        wstate_d = wstate_q;
        wbank_d  = wbank_q;
        wcnt_d   = wcnt_q;
        we       = 1'b0;
        set_full = 1'b0;
        ovf_set  = 1'b0;
        par_set  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (accept) begin
                    wcnt_d = AW'(1);
                    if (target_empty) begin
                        we       = 1'b1;
                        wstate_d = W_FILL;
                    end else begin
                        ovf_set  = 1'b1;
                        wstate_d = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    we = 1'b1;
                    if (wcnt_q == LAST_ADDR) begin
                        set_full = 1'b1;
                        wbank_d  = ~wbank_q;
                        wcnt_d   = '0;
                        wstate_d = W_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + AW'(1);
                    end
                end else if (gap) begin
                    par_set  = 1'b1;
                    wcnt_d   = '0;
                    wstate_d = W_IDLE;
                end
            end
            W_DROP: begin
                // Swallow the rest of the dropped frame so the next frame
                // start is recognised on a true frame boundary.
                if (accept) begin
                    if (wcnt_q == LAST_ADDR) begin
                        wcnt_d   = '0;
                        wstate_d = W_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + AW'(1);
                    end
                end else if (gap) begin
                    wcnt_d   = '0;
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                wcnt_d   = '0;
                wstate_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d[wbank_q] = 1'b1;
        end
        if (rel) begin
            full_d[obank_q] = 1'b0;
        end
        overflow_d = ovf_set | (overflow_q & ~status_clr);
        partial_d  = par_set | (partial_q & ~status_clr);
    end

    // ---------------------------------------------------------------------
    // Reader: read issue into the RAM
    // ---------------------------------------------------------------------
    assign pop      = dout_valid & dout_ready;
    // Issue is blocked only when both output entries are occupied and
    // nothing leaves this cycle.
    assign issue_ok = ~(vld_s_q & vld_a_q & ~pop);
    assign raddr    = BIT_REV ? bitrev(iaddr_q) : iaddr_q;

    always_comb begin
        rstate_d = rstate_q;
        ibank_d  = ibank_q;
        iaddr_d  = iaddr_q;
        issue    = 1'b0;
        if (issue_ok && (rstate_q == R_STREAM || full_q[ibank_q])) begin
            issue = 1'b1;
            if (iaddr_q == LAST_ADDR) begin
                // Move on to the other bank right away so consecutive frames
                // stream without a bubble.
                iaddr_d  = '0;
                ibank_d  = ~ibank_q;
                rstate_d = R_IDLE;
            end else begin
                iaddr_d  = iaddr_q + AW'(1);
                rstate_d = R_STREAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= di;
        end
        if (issue) begin
            ram_rd <= mem[{ibank_q, raddr}];
        end
    end

    // ---------------------------------------------------------------------
    // Output skid stage
    // ---------------------------------------------------------------------
    always_comb begin
        s_data_d = s_data_q;
        s_idx_d  = s_idx_q;
        s_last_d = s_last_q;
        vld_s_d  = vld_s_q;
        // A moves into S when S drains, or when a new read would overwrite
        // an A that is not being taken.
        move_a = vld_a_q & ((vld_s_q & pop) | (~vld_s_q & ~pop & issue));
        if (move_a) begin
            s_data_d = ram_rd;
            s_idx_d  = a_idx_q;
            s_last_d = a_last_q;
            vld_s_d  = 1'b1;
        end else if (vld_s_q & pop) begin
            vld_s_d = 1'b0;
        end
        vld_a_d  = issue | (vld_a_q & ~pop);
        a_idx_d  = issue ? raddr : a_idx_q;
        a_last_d = issue ? (iaddr_q == LAST_ADDR) : a_last_q;
    end

    assign cur_last = vld_s_q ? s_last_q : a_last_q;
    assign rel      = pop & cur_last;
    assign obank_d  = rel ? ~obank_q : obank_q;

    always_comb begin
        dout_valid = vld_s_q | vld_a_q;
        dout       = '0;
        dout_idx   = '0;
        dout_last  = 1'b0;
        if (vld_s_q) begin
            dout      = s_data_q;
            dout_idx  = s_idx_q;
            dout_last = s_last_q;
        end else if (vld_a_q) begin
            dout      = ram_rd;
            dout_idx  = a_idx_q;
            dout_last = a_last_q;
        end
    end

    assign overflow = overflow_q;
    assign partial  = partial_q;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        s_data_q <= s_data_d;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wstate_q   <= W_IDLE;
            wbank_q    <= 1'b0;
            wcnt_q     <= '0;
            full_q     <= '0;
            overflow_q <= 1'b0;
            partial_q  <= 1'b0;
            rstate_q   <= R_IDLE;
            ibank_q    <= 1'b0;
            iaddr_q    <= '0;
            obank_q    <= 1'b0;
            vld_a_q    <= 1'b0;
            a_idx_q    <= '0;
            a_last_q   <= 1'b0;
            vld_s_q    <= 1'b0;
            s_idx_q    <= '0;
            s_last_q   <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            wbank_q    <= wbank_d;
            wcnt_q     <= wcnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            partial_q  <= partial_d;
            rstate_q   <= rstate_d;
            ibank_q    <= ibank_d;
            iaddr_q    <= iaddr_d;
            obank_q    <= obank_d;
            vld_a_q    <= vld_a_d;
            a_idx_q    <= a_idx_d;
            a_last_q   <= a_last_d;
            vld_s_q    <= vld_s_d;
            s_idx_q    <= s_idx_d;
            s_last_q   <= s_last_d;
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_frame_capture
//
// Directed bench for frame_capture with N=8, DATA_WIDTH=14. Instance u0 reads
// in natural order, u1 in bit-reversed order; both share all inputs.
// -----------------------------------------------------------------------------
module tb_frame_capture;

    localparam int N  = 8;
    localparam int DW = 14;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 clk_en;
    logic                 di_valid;
    logic signed [DW-1:0] di;
    logic                 dout_ready;
    logic                 status_clr;

    logic                 v0, l0, ovf0, par0;
    logic signed [DW-1:0] d0;
    logic [2:0]           i0;
    logic                 v1, l1, ovf1, par1;
    logic signed [DW-1:0] d1;
    logic [2:0]           i1;

    int errors = 0;
    int checks = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];

    frame_capture #(.N(N), .DATA_WIDTH(DW), .BIT_REV(1'b0)) u0 (
        .clk(clk), .arst_n(arst_n), .clk_en(clk_en), .di_valid(di_valid), .di(di),
        .dout_valid(v0), .dout_ready(dout_ready), .dout(d0), .dout_last(l0),
        .dout_idx(i0), .overflow(ovf0), .partial(par0), .status_clr(status_clr)
    );

    frame_capture #(.N(N), .DATA_WIDTH(DW), .BIT_REV(1'b1)) u1 (
        .clk(clk), .arst_n(arst_n), .clk_en(clk_en), .di_valid(di_valid), .di(di),
        .dout_valid(v1), .dout_ready(dout_ready), .dout(d1), .dout_last(l1),
        .dout_idx(i1), .overflow(ovf1), .partial(par1), .status_clr(status_clr)
    );

    always #5 clk = ~clk;

    // Record every handshake as {last, idx, data}.
    always @(negedge clk) begin
        if (arst_n) begin
            if (v0 && dout_ready) q0.push_back({l0, i0, d0});
            if (v1 && dout_ready) q1.push_back({l1, i1, d1});
        end
    end

    function automatic logic [17:0] pk(input int last, input int idx, input int val);
        logic [17:0] r;
        r = {last[0], idx[2:0], val[13:0]};
        return r;
    endfunction

    function automatic logic [17:0] at0(input int k);
        return (k < q0.size()) ? q0[k] : 18'bx;
    endfunction

    function automatic logic [17:0] at1(input int k);
        return (k < q1.size()) ? q1[k] : 18'bx;
    endfunction

    task automatic do_reset();
        arst_n     = 1'b0;
        clk_en     = 1'b0;
        di_valid   = 1'b0;
        di         = '0;
        status_clr = 1'b0;
        repeat (3) @(posedge clk);
        #3 arst_n = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < N; k++) begin
            di       = DW'(base + k);
            di_valid = 1'b1;
            clk_en   = 1'b1;
            @(posedge clk);
            #1;
        end
        di_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input bit sel);
        for (int t = 0; t < 400; t++) begin
            if ((sel ? q1.size() : q0.size()) >= n) break;
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; clk_en = 1'b0; di_valid = 1'b0; di = '0;
        dout_ready = 1'b0; status_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (v0 !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", v0); end
        checks++; if (d0 !== 14'sd0)  begin errors++; $display("FAIL reset_dout: got %h want 0", d0); end
        checks++; if (i0 !== 3'd0)    begin errors++; $display("FAIL reset_idx: got %0d want 0", i0); end
        checks++; if (l0 !== 1'b0)    begin errors++; $display("FAIL reset_last: got %b want 0", l0); end
        checks++; if (ovf0 !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf0); end
        checks++; if (par0 !== 1'b0)  begin errors++; $display("FAIL reset_partial: got %b want 0", par0); end
        #3 arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_natural();
        do_reset();
        dout_ready = 1'b1;
        send_frame(1);
        @(negedge clk);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL nat_early_valid: got %b want 0", v0); end
        @(negedge clk);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL nat_first_valid: got %b want 1", v0); end
        checks++; if (d0 !== 14'sd1) begin errors++; $display("FAIL nat_first_dout: got %0d want 1", d0); end
        wait_q(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (q0.size() != N) begin errors++; $display("FAIL nat_count: got %0d want %0d", q0.size(), N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (at0(k) !== pk(k == N-1, k, 1 + k))
                begin errors++; $display("FAIL nat_sample%0d: got %h want %h", k, at0(k), pk(k == N-1, k, 1 + k)); end
        end
    endtask

    task automatic test_bitrev();
        int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        do_reset();
        dout_ready = 1'b1;
        send_frame(0);
        wait_q(N, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (q1.size() != N) begin errors++; $display("FAIL brev_count: got %0d want %0d", q1.size(), N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (at1(k) !== pk(k == N-1, br[k], br[k]))
                begin errors++; $display("FAIL brev_sample%0d: got %h want %h", k, at1(k), pk(k == N-1, br[k], br[k])); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        dout_ready = 1'b0;
        send_frame(1);
        send_frame(11);
        send_frame(21);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf0); end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL ovf_stall_count: got %0d want 0", q0.size()); end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL ovf_stall_valid: got %b want 1", v0); end
        checks++; if (d0 !== 14'sd1 || i0 !== 3'd0) begin errors++; $display("FAIL ovf_stall_hold: got %0d/%0d want 1/0", d0, i0); end
        dout_ready = 1'b1;
        wait_q(2*N, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (q0.size() != 2*N) begin errors++; $display("FAIL ovf_count: got %0d want %0d", q0.size(), 2*N); end
        for (int j = 0; j < 2*N; j++) begin
            int k;
            int base;
            k = j % N;
            base = (j < N) ? 1 : 11;
            checks++;
            if (at0(j) !== pk(k == N-1, k, base + k))
                begin errors++; $display("FAIL ovf_sample%0d: got %h want %h", j, at0(j), pk(k == N-1, k, base + k)); end
        end
        status_clr = 1'b1;
        @(posedge clk);
        #1 status_clr = 1'b0;
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
    endtask

    task automatic test_partial();
        do_reset();
        dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            di = DW'(50 + k); di_valid = 1'b1; clk_en = 1'b1;
            @(posedge clk);
            #1;
        end
        di_valid = 1'b0;
        clk_en   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (par0 !== 1'b1) begin errors++; $display("FAIL part_flag: got %b want 1", par0); end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL part_no_output: got %0d want 0", q0.size()); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL part_overflow: got %b want 0", ovf0); end
        send_frame(10);
        wait_q(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (q0.size() != N) begin errors++; $display("FAIL part_count: got %0d want %0d", q0.size(), N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (at0(k) !== pk(k == N-1, k, 10 + k))
                begin errors++; $display("FAIL part_sample%0d: got %h want %h", k, at0(k), pk(k == N-1, k, 10 + k)); end
        end
        status_clr = 1'b1;
        @(posedge clk);
        #1 status_clr = 1'b0;
        checks++; if (par0 !== 1'b0) begin errors++; $display("FAIL part_clear: got %b want 0", par0); end
    endtask

    task automatic test_clk_en();
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 2*N; i++) begin
            clk_en   = (i % 2 == 0);
            di_valid = 1'b1;
            di       = DW'(30 + i / 2);
            @(posedge clk);
            #1;
        end
        di_valid = 1'b0;
        clk_en   = 1'b1;
        wait_q(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (par0 !== 1'b0) begin errors++; $display("FAIL clken_partial: got %b want 0", par0); end
        checks++; if (q0.size() != N) begin errors++; $display("FAIL clken_count: got %0d want %0d", q0.size(), N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (at0(k) !== pk(k == N-1, k, 30 + k))
                begin errors++; $display("FAIL clken_sample%0d: got %h want %h", k, at0(k), pk(k == N-1, k, 30 + k)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dout_ready = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(40 + 10*f);
        wait_q(4*N, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", ovf0); end
        checks++; if (q0.size() != 4*N) begin errors++; $display("FAIL b2b_count: got %0d want %0d", q0.size(), 4*N); end
        for (int j = 0; j < 4*N; j++) begin
            int k;
            k = j % N;
            checks++;
            if (at0(j) !== pk(k == N-1, k, 40 + 10*(j / N) + k))
                begin errors++; $display("FAIL b2b_sample%0d: got %h want %h", j, at0(j), pk(k == N-1, k, 40 + 10*(j / N) + k)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dout_ready = 1'b1;
        send_frame(80);
        wait_q(3, 1'b0);
        @(negedge clk);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", v0); end
        #2 arst_n = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", v0); end
        checks++; if (d0 !== 14'sd0 || i0 !== 3'd0 || l0 !== 1'b0)
            begin errors++; $display("FAIL midrst_outputs: got %0d/%0d/%b want 0/0/0", d0, i0, l0); end
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        send_frame(90);
        wait_q(N, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (q0.size() != N) begin errors++; $display("FAIL midrst_count: got %0d want %0d", q0.size(), N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (at0(k) !== pk(k == N-1, k, 90 + k))
                begin errors++; $display("FAIL midrst_sample%0d: got %h want %h", k, at0(k), pk(k == N-1, k, 90 + k)); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 6; f++) begin
            int k;
            k = 0;
            while (k < N) begin
                clk_en     = $urandom_range(0, 1);
                dout_ready = ($urandom_range(0, 3) != 0);
                di_valid   = 1'b1;
                di         = DW'(100 + f*N + k);
                @(posedge clk);
                #1;
                if (clk_en) k++;
            end
            di_valid = 1'b0;
            for (int g = 0; g < 16; g++) begin
                clk_en     = $urandom_range(0, 1);
                dout_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end
        dout_ready = 1'b1;
        wait_q(6*N, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (ovf0 !== 1'b0 || par0 !== 1'b0) begin errors++; $display("FAIL rand_flags: got %b/%b want 0/0", ovf0, par0); end
        checks++; if (q0.size() != 6*N) begin errors++; $display("FAIL rand_count: got %0d want %0d", q0.size(), 6*N); end
        for (int j = 0; j < 6*N; j++) begin
            int k;
            k = j % N;
            checks++;
            if (at0(j) !== pk(k == N-1, k, 100 + j))
                begin errors++; $display("FAIL rand_sample%0d: got %h want %h", j, at0(j), pk(k == N-1, k, 100 + j)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_natural();
        test_bitrev();
        test_overflow();
        test_partial();
        test_clk_en();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
